// File: rtl/vpu_wb_arbiter.sv
// Vector writeback arbiter: grants one functional-unit result per cycle into a
// single registered regfile write port. Define VPU_WB_RR_EN for round-robin arbitration.
module vpu_wb_arbiter #(
  parameter int VLEN    = 64,
  parameter int NUM_SRC = 3
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_SRC-1:0]                src_valid_i,
  output logic [NUM_SRC-1:0]                src_ready_o,
  input  logic [NUM_SRC-1:0][4:0]           src_addr_i,
  input  logic [NUM_SRC-1:0][VLEN/8-1:0]    src_bweb_i,
  input  logic [NUM_SRC-1:0][VLEN-1:0]      src_data_i,
  input  logic                              flush_i,
  output logic                              vreg_write_en_o,
  output logic [4:0]                        vreg_write_addr_o,
  output logic [VLEN/8-1:0]                 vreg_write_bweb_o,
  output logic [VLEN-1:0]                   vreg_write_data_o,
  output logic                              wb_done_o,
  output logic [4:0]                        wb_done_addr_o,
  output logic [1:0]                        wb_done_src_o,
  output logic                              busy_o
);

  logic       grant_vld;
  logic [1:0] grant_idx;
  logic       grant_fire;
  logic [2:0] cand;

`ifdef VPU_WB_RR_EN
  logic [1:0] rr_ptr;
`endif

  // Walk the sources in priority order; the first valid one wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
`ifdef VPU_WB_RR_EN
      cand = {1'b0, rr_ptr} + 3'(i);
      if (cand >= 3'(NUM_SRC)) cand = cand - 3'(NUM_SRC);
`else
      cand = 3'(i);
`endif
      if (!grant_vld && (cand < 3'(NUM_SRC)) && src_valid_i[cand[1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[1:0];
      end
    end
  end

  assign grant_fire = grant_vld && !flush_i;

  always_comb begin
    src_ready_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src_ready_o[k] = grant_fire && (grant_idx == 2'(k));
    end
  end

`ifdef VPU_WB_RR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (grant_fire) begin
      rr_ptr <= (grant_idx == 2'(NUM_SRC - 1)) ? 2'd0 : grant_idx + 2'd1;
    end
  end
`endif

  // The regfile never back-pressures, so the stage holds a result for exactly
  // one cycle and otherwise presents all-zero outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vreg_write_en_o   <= 1'b0;
      vreg_write_addr_o <= '0;
      vreg_write_bweb_o <= '0;
      vreg_write_data_o <= '0;
      wb_done_o         <= 1'b0;
      wb_done_addr_o    <= '0;
      wb_done_src_o     <= '0;
      busy_o            <= 1'b0;
    end else if (grant_fire) begin
      vreg_write_en_o   <= |src_bweb_i[grant_idx];
      vreg_write_addr_o <= src_addr_i[grant_idx];
      vreg_write_bweb_o <= src_bweb_i[grant_idx];
      vreg_write_data_o <= src_data_i[grant_idx];
      wb_done_o         <= 1'b1;
      wb_done_addr_o    <= src_addr_i[grant_idx];
      wb_done_src_o     <= grant_idx;
      busy_o            <= 1'b1;
    end else begin
      vreg_write_en_o   <= 1'b0;
      vreg_write_addr_o <= '0;
      vreg_write_bweb_o <= '0;
      vreg_write_data_o <= '0;
      wb_done_o         <= 1'b0;
      wb_done_addr_o    <= '0;
      wb_done_src_o     <= '0;
      busy_o            <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vpu_wb_arbiter.sv
// Directed bench for vpu_wb_arbiter: a model picks the expected winner, the
// scoreboard queue holds the expected write that must appear one cycle later.
module tb_vpu_wb_arbiter;

  localparam int VLEN    = 64;
  localparam int NUM_SRC = 3;

  typedef struct {
    logic [4:0]  addr;
    logic [7:0]  bweb;
    logic [63:0] data;
    logic [1:0]  src;
  } exp_t;

  logic                           clk_i = 1'b0;
  logic                           rst_ni;
  logic [NUM_SRC-1:0]             src_valid_i;
  logic [NUM_SRC-1:0]             src_ready_o;
  logic [NUM_SRC-1:0][4:0]        src_addr_i;
  logic [NUM_SRC-1:0][VLEN/8-1:0] src_bweb_i;
  logic [NUM_SRC-1:0][VLEN-1:0]   src_data_i;
  logic                           flush_i;
  logic                           vreg_write_en_o;
  logic [4:0]                     vreg_write_addr_o;
  logic [VLEN/8-1:0]              vreg_write_bweb_o;
  logic [VLEN-1:0]                vreg_write_data_o;
  logic                           wb_done_o;
  logic [4:0]                     wb_done_addr_o;
  logic [1:0]                     wb_done_src_o;
  logic                           busy_o;

  int   vectors     = 0;
  int   miscompares = 0;
  int   mPtr        = 0;
  exp_t sbQ[$];

  vpu_wb_arbiter #(.VLEN(VLEN), .NUM_SRC(NUM_SRC)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .src_valid_i       (src_valid_i),
    .src_ready_o       (src_ready_o),
    .src_addr_i        (src_addr_i),
    .src_bweb_i        (src_bweb_i),
    .src_data_i        (src_data_i),
    .flush_i           (flush_i),
    .vreg_write_en_o   (vreg_write_en_o),
    .vreg_write_addr_o (vreg_write_addr_o),
    .vreg_write_bweb_o (vreg_write_bweb_o),
    .vreg_write_data_o (vreg_write_data_o),
    .wb_done_o         (wb_done_o),
    .wb_done_addr_o    (wb_done_addr_o),
    .wb_done_src_o     (wb_done_src_o),
    .busy_o            (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int modelGrant(input logic [2:0] v, input int ptr);
    int idx;
    for (int i = 0; i < NUM_SRC; i++) begin
`ifdef VPU_WB_RR_EN
      idx = (ptr + i) % NUM_SRC;
`else
      idx = i;
`endif
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic loadSrc(input int k, input logic [4:0] a, input logic [7:0] b, input logic [63:0] d);
    src_addr_i[k] = a;
    src_bweb_i[k] = b;
    src_data_i[k] = d;
  endtask

  // Whatever the scoreboard expects for this cycle must be on the write port;
  // an empty scoreboard means every output reads zero.
  task automatic checkOutput(input string tag);
    exp_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkVal({tag, "_wen"},   64'(vreg_write_en_o),   64'(|e.bweb));
      checkVal({tag, "_waddr"}, 64'(vreg_write_addr_o), 64'(e.addr));
      checkVal({tag, "_wbweb"}, 64'(vreg_write_bweb_o), 64'(e.bweb));
      checkVal({tag, "_wdata"}, vreg_write_data_o,      e.data);
      checkVal({tag, "_done"},  64'(wb_done_o),         64'd1);
      checkVal({tag, "_daddr"}, 64'(wb_done_addr_o),    64'(e.addr));
      checkVal({tag, "_dsrc"},  64'(wb_done_src_o),     64'(e.src));
      checkVal({tag, "_busy"},  64'(busy_o),            64'd1);
    end else begin
      checkVal({tag, "_idle_all"},
               64'({vreg_write_en_o, vreg_write_addr_o, vreg_write_bweb_o, wb_done_o,
                    wb_done_addr_o, wb_done_src_o, busy_o}), 64'd0);
      checkVal({tag, "_idle_data"}, vreg_write_data_o, 64'd0);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] valid, input logic flush, input string tag,
                               output logic [2:0] readySeen);
    int g;
    logic [2:0] expReady;
    exp_t e;
    src_valid_i = valid;
    flush_i     = flush;
    #1;
    g = modelGrant(valid, mPtr);
    expReady = (flush || g < 0) ? 3'b000 : 3'(1 << g);
    readySeen = src_ready_o;
    checkVal({tag, "_ready"}, 64'(src_ready_o), 64'(expReady));
    if (!flush && g >= 0) begin
      e.addr = src_addr_i[g];
      e.bweb = src_bweb_i[g];
      e.data = src_data_i[g];
      e.src  = 2'(g);
      sbQ.push_back(e);
`ifdef VPU_WB_RR_EN
      mPtr = (g + 1) % NUM_SRC;
`endif
    end
    @(posedge clk_i);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [2:0] rdy;
    logic [2:0] contTbl [4];
    rst_ni      = 1'b0;
    src_valid_i = '0;
    flush_i     = 1'b0;
    src_addr_i  = '0;
    src_bweb_i  = '0;
    src_data_i  = '0;
`ifdef VPU_WB_RR_EN
    contTbl = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    contTbl = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif

    #2;
    checkOutput("reset");
    checkVal("reset_ready", 64'(src_ready_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    $display("[TB] single write from src1");
    loadSrc(1, 5'd5, 8'hFF, 64'h0123_4567_89AB_CDEF);
    applyStimulus(3'b010, 1'b0, "single", rdy);
    applyStimulus(3'b000, 1'b0, "single_drain", rdy);

    $display("[TB] partial and empty byte masks from src0");
    loadSrc(0, 5'd3, 8'h0F, 64'hAAAA_5555_AAAA_5555);
    applyStimulus(3'b001, 1'b0, "mask0f", rdy);
    loadSrc(0, 5'd3, 8'h00, 64'h1111_2222_3333_4444);
    applyStimulus(3'b001, 1'b0, "mask00", rdy);
    applyStimulus(3'b000, 1'b0, "mask_drain", rdy);

    $display("[TB] flush holds off grant but not the staged write");
    loadSrc(0, 5'd7, 8'hF0, 64'hDEAD_BEEF_0000_0007);
    loadSrc(2, 5'd9, 8'h3C, 64'hCAFE_F00D_0000_0009);
    applyStimulus(3'b001, 1'b0, "pre_flush", rdy);
    applyStimulus(3'b100, 1'b1, "flush", rdy);
    applyStimulus(3'b100, 1'b0, "post_flush", rdy);
    applyStimulus(3'b000, 1'b0, "flush_drain", rdy);

    $display("[TB] async reset discards the staged entry");
    loadSrc(1, 5'd12, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD);
    applyStimulus(3'b010, 1'b0, "pre_reset", rdy);
    src_valid_i = '0;
    #2;
    rst_ni = 1'b0;
    #1;
    checkVal("mid_reset_wen",  64'(vreg_write_en_o), 64'd0);
    checkVal("mid_reset_done", 64'(wb_done_o),       64'd0);
    checkVal("mid_reset_busy", 64'(busy_o),          64'd0);
    sbQ.delete();
    mPtr = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("post_reset");

    $display("[TB] contention with all sources valid");
    loadSrc(0, 5'd1, 8'h01, 64'h0000_0000_0000_00A0);
    loadSrc(1, 5'd2, 8'h02, 64'h0000_0000_0000_00B1);
    loadSrc(2, 5'd4, 8'h04, 64'h0000_0000_0000_00C2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b111, 1'b0, $sformatf("contend%0d", i), rdy);
      checkVal($sformatf("contend%0d_table", i), 64'(rdy), 64'(contTbl[i]));
    end
    applyStimulus(3'b000, 1'b0, "contend_drain", rdy);

    $display("[TB] throughput from src0");
    for (int i = 0; i < 8; i++) begin
      loadSrc(0, 5'(16 + i), 8'hFF, 64'h5A5A_0000_0000_0000 | 64'(i));
      applyStimulus(3'b001, 1'b0, $sformatf("thru%0d", i), rdy);
    end
    applyStimulus(3'b000, 1'b0, "thru_drain", rdy);
    checkVal("scoreboard_empty", 64'(sbQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
